// File: rtl/seven_segment_pkg.sv
// Shared types for the seven-segment display arbiter.
package seven_segment_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_BLANK = 4'hF;

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    OPEN
  } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first asserted request searching upward from last+1 with wrap.
module rr_pick #(
  parameter int REQ = 3,
  parameter int IW  = $clog2(REQ)
) (
  input  logic [REQ-1:0] req,
  input  logic [IW-1:0]  last,
  input  logic           exclude_owner,
  output logic [REQ-1:0] pick,
  output logic [IW-1:0]  idx,
  output logic           any
);

  logic [REQ-1:0] owner_hot;
  logic [REQ-1:0] masked;

  always_comb begin
    owner_hot = '0;
    for (int k = 0; k < REQ; k++) begin
      owner_hot[k] = (IW'(k) == last);
    end
    masked = req;
    if (exclude_owner && (|(req & ~owner_hot))) begin
      masked = req & ~owner_hot;
    end
    any  = |masked;
    pick = '0;
    idx  = '0;
    // Walk from farthest to nearest so the nearest hit after last is written last.
    for (int k = REQ; k >= 1; k--) begin
      int j;
      j = int'(last) + k;
      if (j >= REQ) j = j - REQ;
      if (masked[j]) begin
        pick = REQ'(1) << j;
        idx  = IW'(j);
      end
    end
  end

endmodule

// File: rtl/seven_segment_arbiter.sv
// Round-robin owner of a shared NUM-digit BCD display with a minimum dwell per grant.
// Handshake: req is a level; grant/valid/bcd_out follow one cycle after the sampling edge.
module seven_segment_arbiter
  import seven_segment_pkg::*;
#(
  parameter int NUM      = 6,
  parameter int REQ      = 3,
  parameter int CLOCK_HZ = 50000000,
  parameter int DWELL_HZ = 2
) (
  input  logic                           clock,
  input  logic                           reset_n,
  input  logic       [REQ-1:0]           req,
  input  bcd_digit_t [REQ-1:0][NUM-1:0]  bcd_in,
  output logic       [REQ-1:0]           grant,
  output logic                           valid,
  output bcd_digit_t [NUM-1:0]           bcd_out,
  output logic                           switch_pulse,
  output arb_state_t                     state_dbg
);

  localparam int DWELL = CLOCK_HZ / DWELL_HZ;
  localparam int TW    = $clog2(DWELL + 1);
  localparam int IW    = $clog2(REQ);

  if (DWELL < 1) begin : g_bad_dwell
    $error("seven_segment_arbiter: DWELL must be at least 1 cycle");
  end
  if (REQ < 2) begin : g_bad_req
    $error("seven_segment_arbiter: REQ must be at least 2");
  end

  arb_state_t            state, state_n;
  logic [TW-1:0]         timer, timer_n;
  logic [IW-1:0]         last, last_n;
  logic [REQ-1:0]        grant_n;
  logic                  valid_n;
  bcd_digit_t [NUM-1:0]  bcd_n;
  logic                  sw_n;

  logic [REQ-1:0]        pick;
  logic [IW-1:0]         pick_idx;
  logic                  pick_any;
  logic                  others;
  logic                  owner_req;
  logic                  dwell_done;
  logic                  take;
  logic                  go_idle;

  rr_pick #(.REQ(REQ), .IW(IW)) u_pick (
    .req           (req),
    .last          (last),
    .exclude_owner (state != IDLE),
    .pick          (pick),
    .idx           (pick_idx),
    .any           (pick_any)
  );

  assign others     = |(req & ~grant);
  assign owner_req  = req[last];
  assign dwell_done = (timer == TW'(DWELL - 1));
  assign state_dbg  = state;

  always_comb begin
    state_n = state;
    timer_n = timer;
    last_n  = last;
    grant_n = grant;
    valid_n = valid;
    bcd_n   = bcd_out;
    sw_n    = 1'b0;
    take    = 1'b0;
    go_idle = 1'b0;
    case (state)
      IDLE: begin
        if (pick_any) take = 1'b1;
      end
      HOLD: begin
        if (owner_req) bcd_n = bcd_in[last];
        if (timer != TW'(DWELL)) timer_n = timer + TW'(1);
        if (dwell_done) begin
          if (others) begin
            take = 1'b1;
            sw_n = 1'b1;
          end else if (owner_req) begin
            state_n = OPEN;
          end else begin
            go_idle = 1'b1;
          end
        end
      end
      OPEN: begin
        if (owner_req) bcd_n = bcd_in[last];
        // A waiting requester wins even when the owner lets go in the same cycle.
        if (others) begin
          take = 1'b1;
          sw_n = 1'b1;
        end else if (!owner_req) begin
          go_idle = 1'b1;
        end
      end
      default: go_idle = 1'b1;
    endcase
    if (take) begin
      state_n = HOLD;
      grant_n = pick;
      valid_n = 1'b1;
      bcd_n   = bcd_in[pick_idx];
      timer_n = '0;
      last_n  = pick_idx;
    end
    if (go_idle) begin
      state_n = IDLE;
      grant_n = '0;
      valid_n = 1'b0;
      bcd_n   = {NUM{BCD_BLANK}};
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      timer        <= '0;
      last         <= IW'(REQ - 1);
      grant        <= '0;
      valid        <= 1'b0;
      bcd_out      <= {NUM{BCD_BLANK}};
      switch_pulse <= 1'b0;
    end else begin
      state        <= state_n;
      timer        <= timer_n;
      last         <= last_n;
      grant        <= grant_n;
      valid        <= valid_n;
      bcd_out      <= bcd_n;
      switch_pulse <= sw_n;
    end
  end

endmodule

// File: tb/tb_seven_segment_arbiter.sv
// Bench for seven_segment_arbiter with DWELL = 10 cycles, REQ = 3, NUM = 6.
module tb_seven_segment_arbiter;
  import seven_segment_pkg::*;

  localparam int REQ = 3;
  localparam int NUM = 6;
  localparam int W   = 29;
  localparam logic [W-1:0] RST_EXP = {3'b000, 1'b0, 24'hFFFFFF, 1'b0};
  localparam logic [23:0] B0 = 24'h111111;
  localparam logic [23:0] B1 = 24'h123456;
  localparam logic [23:0] B2 = 24'h222222;

  logic clock = 1'b0;
  logic reset_n;
  logic [REQ-1:0] req;
  logic [REQ-1:0][23:0] bcd_in;
  logic [REQ-1:0] grant;
  logic valid;
  logic [23:0] bcd_out;
  logic switch_pulse;
  arb_state_t state_dbg;

  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail = 0;

  typedef struct {
    logic        rst;
    logic [2:0]  req;
    logic [23:0] b0, b1, b2;
    int          reps;
    logic [2:0]  g;
    logic        v;
    logic [23:0] bo;
    logic        sw;
  } vec_t;
  vec_t tbl[$];

  seven_segment_arbiter #(
    .NUM(NUM), .REQ(REQ), .CLOCK_HZ(100), .DWELL_HZ(10)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .req          (req),
    .bcd_in       (bcd_in),
    .grant        (grant),
    .valid        (valid),
    .bcd_out      (bcd_out),
    .switch_pulse (switch_pulse),
    .state_dbg    (state_dbg)
  );

  // Clock and reset
  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic vec_t mk(input logic rst, input logic [2:0] rq,
                              input logic [23:0] b0, input logic [23:0] b1, input logic [23:0] b2,
                              input int reps, input logic [2:0] g, input logic v,
                              input logic [23:0] bo, input logic sw);
    vec_t r;
    r.rst = rst; r.req = rq; r.b0 = b0; r.b1 = b1; r.b2 = b2;
    r.reps = reps; r.g = g; r.v = v; r.bo = bo; r.sw = sw;
    return r;
  endfunction

  function automatic logic [W-1:0] outs();
    return {grant, valid, bcd_out, switch_pulse};
  endfunction

  // Driver tasks
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got grant=%b valid=%b bcd=%h sw=%b, want grant=%b valid=%b bcd=%h sw=%b",
               name, act[28:26], act[25], act[24:1], act[0], exp[28:26], exp[25], exp[24:1], exp[0]);
    end
  endtask

  // Called 1 time unit after a rising edge: reset is applied and checked between edges.
  task automatic pulse_reset();
    reset_n = 1'b0;
    #2;
    check("async_reset", outs(), RST_EXP);
    reset_n = 1'b1;
  endtask

  task automatic run_row(input int r);
    vec_t v;
    v = tbl[r];
    if (v.rst) pulse_reset();
    for (int i = 0; i < v.reps; i++) begin
      req = v.req;
      bcd_in[0] = v.b0;
      bcd_in[1] = v.b1;
      bcd_in[2] = v.b2;
      exp_q.push_back({v.g, v.v, v.bo, v.sw});
      tick();
      check($sformatf("row%0d_cyc%0d", r, i), outs(), exp_q.pop_front());
    end
  endtask

  initial begin
    reset_n = 1'b0;
    req = '0;
    bcd_in = '0;
    repeat (2) tick();
    check("reset_state", outs(), RST_EXP);
    reset_n = 1'b1;
    tick();
    check("idle_no_req", outs(), RST_EXP);

    // Hand sequence: grant, then async reset between edges clears outputs at once.
    req = 3'b100;
    bcd_in[2] = B2;
    tick();
    check("grant_before_reset", outs(), {3'b100, 1'b1, B2, 1'b0});
    #2;
    reset_n = 1'b0;
    #1;
    check("midcycle_reset", outs(), RST_EXP);
    #1;
    reset_n = 1'b1;
    req = '0;
    tick();
    check("idle_after_reset", outs(), RST_EXP);

    // Single requester holds indefinitely and bcd_out tracks its input.
    tbl.push_back(mk(1, 3'b010, B0, 24'h123456, B2, 2,  3'b010, 1, 24'h123456, 0));
    tbl.push_back(mk(0, 3'b010, B0, 24'h000789, B2, 1,  3'b010, 1, 24'h000789, 0));
    tbl.push_back(mk(0, 3'b010, B0, 24'h000789, B2, 20, 3'b010, 1, 24'h000789, 0));
    tbl.push_back(mk(0, 3'b010, B0, 24'h654321, B2, 1,  3'b010, 1, 24'h654321, 0));
    tbl.push_back(mk(0, 3'b000, B0, 24'h654321, B2, 2,  3'b000, 0, 24'hFFFFFF, 0));
    // Two contenders alternate every DWELL cycles.
    tbl.push_back(mk(1, 3'b101, B0, B1, B2, 10, 3'b001, 1, B0, 0));
    tbl.push_back(mk(0, 3'b101, B0, B1, B2, 1,  3'b100, 1, B2, 1));
    tbl.push_back(mk(0, 3'b101, B0, B1, B2, 9,  3'b100, 1, B2, 0));
    tbl.push_back(mk(0, 3'b101, B0, B1, B2, 1,  3'b001, 1, B0, 1));
    // Three contenders rotate 0,1,2,0.
    tbl.push_back(mk(1, 3'b111, B0, B1, B2, 10, 3'b001, 1, B0, 0));
    tbl.push_back(mk(0, 3'b111, B0, B1, B2, 1,  3'b010, 1, B1, 1));
    tbl.push_back(mk(0, 3'b111, B0, B1, B2, 9,  3'b010, 1, B1, 0));
    tbl.push_back(mk(0, 3'b111, B0, B1, B2, 1,  3'b100, 1, B2, 1));
    tbl.push_back(mk(0, 3'b111, B0, B1, B2, 9,  3'b100, 1, B2, 0));
    tbl.push_back(mk(0, 3'b111, B0, B1, B2, 1,  3'b001, 1, B0, 1));
    tbl.push_back(mk(0, 3'b111, B0, B1, B2, 9,  3'b001, 1, B0, 0));
    // Owner drops during HOLD: display frozen until the dwell ends, then blank.
    tbl.push_back(mk(1, 3'b001, 24'h000042, B1, B2, 5, 3'b001, 1, 24'h000042, 0));
    tbl.push_back(mk(0, 3'b000, 24'h999999, B1, B2, 5, 3'b001, 1, 24'h000042, 0));
    tbl.push_back(mk(0, 3'b000, 24'h999999, B1, B2, 1, 3'b000, 0, 24'hFFFFFF, 0));
    // Owner 1 in OPEN, reset: the pointer restarts so requester 0 wins.
    tbl.push_back(mk(1, 3'b010, B0, B1, B2, 12, 3'b010, 1, B1, 0));
    tbl.push_back(mk(1, 3'b011, B0, B1, B2, 10, 3'b001, 1, B0, 0));
    tbl.push_back(mk(0, 3'b011, B0, B1, B2, 1,  3'b010, 1, B1, 1));
    // Owner releases in OPEN while another requests: switch beats going idle.
    tbl.push_back(mk(0, 3'b010, B0, B1, B2, 12, 3'b010, 1, B1, 0));
    tbl.push_back(mk(0, 3'b001, B0, B1, B2, 1,  3'b001, 1, B0, 1));
    tbl.push_back(mk(0, 3'b001, B0, B1, B2, 1,  3'b001, 1, B0, 0));

    for (int r = 0; r < tbl.size(); r++) run_row(r);

    // Final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
